memory_unit: RTL and testbench
==============================

// Module: memory_unit
// PURPOSE
//   Byte-addressed, big-endian unified main memory for the MIPS processor model. Holds
//   program text and data loaded from hex images, starting at base address 0x80020000.
//   Serves single-word and burst (4/8/16-word) reads and writes over a simple
//   enable/busy interface. Shared by the instruction-fetch and load/store paths.
// PARAMETERS
//   DATA_WIDTH     32            data bus width, bits
//   ADDRESS_WIDTH  32            address bus width, bits
//   DEPTH          1048576       storage size, bytes
//   START_ADDR     32'h80020000  byte address mapped to storage offset 0
// PORTS
//   clock        in   1   single clock; all state changes on the rising edge
//   reset_n      in   1   asynchronous, active-low reset
//   address      in   32  byte address of the first beat; sampled at the start edge
//   data_in      in   32  write data; sampled on every write-beat edge
//   access_size  in   2   00=1 word, 01=4 words, 10=8 words, 11=16 words
//   rw           in   1   0=write, 1=read
//   enable       in   1   request strobe; honoured only while busy=0
//   busy         out  1   high while a burst is in progress past its first beat
//   data_out     out  32  registered read data, one word per beat
// BEHAVIOUR
//   - Reset (reset_n=0, asynchronous): busy=0, data_out=0, beat counter=0, and any
//     burst is aborted. Storage contents are not cleared.
//   - Start: on a rising edge with enable=1 and busy=0, latch address, rw and
//     access_size. Beat 0 executes on this same edge. N = 1/4/8/16 from access_size.
//   - Beat k (0..N-1) executes on the k-th edge after the start edge. Beat k uses byte
//     address A+4k, with A = latched address and bits [1:0] forced to 0.
//   - Write beat: store data_in big-endian: [31:24] at offset+0 ... [7:0] at offset+3.
//   - Read beat: data_out <= the big-endian word at that offset, visible after the edge
//     (latency 1 cycle). data_out holds its last value when no read beat occurs.
//   - busy: if N>1, busy=1 from the start edge through the edge of beat N-1, then 0.
//     For N=1, busy stays 0. A new request can therefore be accepted on the edge after
//     the last beat.
//   - enable, rw, access_size and address are ignored while busy=1; a burst always
//     runs to completion unless reset.
//   - Range: offset = addr - START_ADDR, computed as an unsigned 32-bit value.
//     A beat is in range iff offset <= DEPTH-4. Out-of-range writes are dropped;
//     out-of-range reads return 32'h0. A burst that runs past the top of memory
//     continues to count beats, applying the same rule per beat; there is no wrap.
//   - Storage contents are undefined (X) until written.
// STRUCTURE
//   - Package memory_pkg: START_ADDR, DEPTH, access-size encodings
//     (AS_1W, AS_4W, AS_8W, AS_16W), RW_WRITE=0 / RW_READ=1, and a function
//     burst_len(access_size) returning 1/4/8/16.
//   - One sub-module, memory_array: a DEPTH x 8 byte store with one 32-bit big-endian
//     word read/write port (we, word offset, wdata, rdata). The top level holds the
//     request latch, beat counter, busy logic, range check and data_out register.
// TESTING
//   1. Single write/read: write 32'h3C1D8002 to 0x80020000 (AS 00); read it back next
//      -> data_out=32'h3C1D8002 one cycle after the read edge; busy never rises.
//   2. Endianness: write 32'hAABBCCDD to 0x80020004; read 0x80020004 and 0x80020006
//      -> both return 32'hAABBCCDD (low address bits ignored); bytes ordered AA,BB,CC,DD.
//   3. 4-word burst: write 1,2,3,4 at 0x80020100 (AS 01); busy=1 for 3 cycles after
//      start; 4-word burst read -> data_out=1,2,3,4 on consecutive cycles.
//   4. Range: write 32'hDEADBEEF to 0x8011FFFC -> readback correct; write to
//      0x80120000 and 0x00000000 -> reads return 32'h0.
//   5. Reset mid-burst: start a 16-word read, drive reset_n=0 at beat 5 -> busy=0 and
//      data_out=0 immediately; after release, a single read returns stored data.
//   6. Enable while busy: pulse enable with rw=0 mid-burst -> ignored; no extra write.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared constants and helpers for the MIPS unified main memory.
package memory_pkg;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned ADDRESS_WIDTH = 32;
  localparam int unsigned DEPTH         = 1048576;
  localparam logic [31:0] START_ADDR    = 32'h8002_0000;

  typedef enum logic [1:0] {
    AS_1W  = 2'b00,
    AS_4W  = 2'b01,
    AS_8W  = 2'b10,
    AS_16W = 2'b11
  } access_size_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     rw;
    logic [1:0]               as;
  } req_t;

  function automatic logic [4:0] burst_len(input logic [1:0] as);
    case (as)
      AS_1W:   burst_len = 5'd1;
      AS_4W:   burst_len = 5'd4;
      AS_8W:   burst_len = 5'd8;
      default: burst_len = 5'd16;
    endcase
  endfunction
endpackage

// File: rtl/memory_array.sv
// Byte store with a single 32-bit big-endian word port; write is synchronous, read is combinational.
module memory_array
  import memory_pkg::*;
#(
  parameter int unsigned DEPTH_B = DEPTH,
  parameter int unsigned WAW     = $clog2(DEPTH_B / 4)
) (
  input  logic           clock,
  input  logic           we,
  input  logic [WAW-1:0] widx,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata
);
  logic [7:0]     r_mem [DEPTH_B];
  logic [WAW+1:0] w_base;

  assign w_base = {widx, 2'b00};

  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[w_base]         <= wdata[31:24];
      r_mem[w_base + 'd1]   <= wdata[23:16];
      r_mem[w_base + 'd2]   <= wdata[15:8];
      r_mem[w_base + 'd3]   <= wdata[7:0];
    end
  end

  assign rdata = {r_mem[w_base], r_mem[w_base + 'd1],
                  r_mem[w_base + 'd2], r_mem[w_base + 'd3]};
endmodule

// File: rtl/memory_unit.sv
// Unified main memory: request latch, beat sequencing, range check and registered read data.
module memory_unit
  import memory_pkg::*;
#(
  parameter int unsigned DW  = DATA_WIDTH,
  parameter int unsigned AW  = ADDRESS_WIDTH,
  parameter int unsigned DEP = DEPTH
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] data_in,
  input  logic [1:0]    access_size,
  input  logic          rw,
  input  logic          enable,
  output logic          busy,
  output logic [DW-1:0] data_out
);
  localparam int unsigned    WAW      = $clog2(DEP / 4);
  localparam logic [AW-1:0]  LAST_OFF = AW'(DEP - 4);

  req_t           r_req;
  logic [3:0]     r_cnt;
  logic           r_busy;
  logic [DW-1:0]  r_data_out;

  logic           w_start, w_beat, w_rw, w_inrng, w_we, w_last;
  logic [1:0]     w_as;
  logic [3:0]     w_k;
  logic [4:0]     w_len;
  logic [AW-1:0]  w_base, w_addr, w_off;
  logic [WAW-1:0] w_widx;
  logic [31:0]    w_rdata;

  // Beat 0 runs on the start edge straight from the ports; later beats use the latch.
  assign w_start = enable & ~r_busy;
  assign w_beat  = w_start | r_busy;
  assign w_base  = w_start ? (address & ~AW'(3)) : r_req.addr;
  assign w_rw    = w_start ? rw          : r_req.rw;
  assign w_as    = w_start ? access_size : r_req.as;
  assign w_k     = w_start ? 4'd0        : r_cnt;
  assign w_addr  = w_base + {{(AW-6){1'b0}}, w_k, 2'b00};
  assign w_off   = w_addr - START_ADDR;
  assign w_inrng = (w_off <= LAST_OFF);
  assign w_widx  = w_off[WAW+1:2];
  assign w_len   = burst_len(w_as);
  assign w_last  = ({1'b0, w_k} == (w_len - 5'd1));
  assign w_we    = w_beat & (w_rw == RW_WRITE) & w_inrng;

  memory_array #(.DEPTH_B(DEP), .WAW(WAW)) u_array (
    .clock (clock),
    .we    (w_we),
    .widx  (w_widx),
    .wdata (data_in[31:0]),
    .rdata (w_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_req      <= '0;
      r_cnt      <= 4'd0;
      r_busy     <= 1'b0;
      r_data_out <= '0;
    end else if (w_beat) begin
      if (w_start) r_req <= '{addr: w_base, rw: w_rw, as: w_as};
      r_busy <= ~w_last;
      r_cnt  <= w_last ? 4'd0 : (w_k + 4'd1);
      if (w_rw == RW_READ) r_data_out <= w_inrng ? DW'(w_rdata) : '0;
    end
  end

  assign busy     = r_busy;
  assign data_out = r_data_out;
endmodule

// File: tb/tb_memory_unit.sv
// Directed scoreboard bench for memory_unit: reads push expected words, a monitor compares them.
`timescale 1ns/1ps
module tb_memory_unit;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] address, data_in, data_out;
  logic [1:0]  access_size;
  logic        rw, enable, busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic        tb_rd_beat = 1'b0;
  logic        rd_cap = 1'b0;
  logic [31:0] wbuf [16];
  logic [31:0] ebuf [16];

  memory_unit dut (
    .clock(clock), .reset_n(reset_n), .address(address), .data_in(data_in),
    .access_size(access_size), .rw(rw), .enable(enable), .busy(busy), .data_out(data_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int blen(input logic [1:0] as);
    return (as == 2'b00) ? 1 : (as == 2'b01) ? 4 : (as == 2'b10) ? 8 : 16;
  endfunction

  // Monitor: a read beat issued on edge E is checked at the following negedge.
  always @(posedge clock) rd_cap <= tb_rd_beat;
  always @(negedge clock) begin
    if (rd_cap) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_data: got %h with no expected word queued", data_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("FAIL rd_data: got %h expected %h", data_out, e);
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [1:0] as,
                          input logic [31:0] d [16], input int glitch);
    int n;
    n = blen(as);
    address = a; access_size = as; rw = 1'b0; enable = 1'b1; data_in = d[0];
    for (int k = 0; k < n; k++) begin
      if (k > 0) data_in = d[k];
      if (k == glitch) begin
        enable = 1'b1; address = 32'h8002_0000; access_size = 2'b00; rw = 1'b0;
      end
      @(posedge clock); #1;
      enable = 1'b0; address = a; access_size = as;
      chk("wr_busy", {31'b0, busy}, {31'b0, (k < n - 1)});
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] as,
                         input logic [31:0] e [16], input int cnt);
    int n;
    n = blen(as);
    address = a; access_size = as; rw = 1'b1; enable = 1'b1;
    for (int k = 0; k < cnt; k++) exp_q.push_back(e[k]);
    tb_rd_beat = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      @(posedge clock); #1;
      enable = 1'b0;
      chk("rd_busy", {31'b0, busy}, {31'b0, (k < n - 1)});
    end
    tb_rd_beat = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; rw = 1'b1; address = '0; data_in = '0; access_size = 2'b00;
    #22;
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_dout", data_out, 32'h0);
    @(posedge clock); #1; reset_n = 1'b1;

    // Single word write / read
    wbuf[0] = 32'h3C1D_8002; ebuf[0] = 32'h3C1D_8002;
    do_write(32'h8002_0000, 2'b00, wbuf, -1);
    do_read(32'h8002_0000, 2'b00, ebuf, 1);

    // Endianness and low address bits
    wbuf[0] = 32'hAABB_CCDD; ebuf[0] = 32'hAABB_CCDD;
    do_write(32'h8002_0004, 2'b00, wbuf, -1);
    do_read(32'h8002_0004, 2'b00, ebuf, 1);
    do_read(32'h8002_0006, 2'b00, ebuf, 1);
    chk("byte4", {24'b0, dut.u_array.r_mem[4]}, 32'hAA);
    chk("byte5", {24'b0, dut.u_array.r_mem[5]}, 32'hBB);
    chk("byte6", {24'b0, dut.u_array.r_mem[6]}, 32'hCC);
    chk("byte7", {24'b0, dut.u_array.r_mem[7]}, 32'hDD);

    // 4-word burst
    for (int k = 0; k < 4; k++) begin wbuf[k] = k + 1; ebuf[k] = k + 1; end
    do_write(32'h8002_0100, 2'b01, wbuf, -1);
    do_read(32'h8002_0100, 2'b01, ebuf, 4);
    wbuf[0] = 32'h55;
    do_write(32'h8002_0040, 2'b00, wbuf, -1);
    @(negedge clock);
    chk("dout_hold", data_out, 32'h4);

    // Range boundaries
    wbuf[0] = 32'hDEAD_BEEF; ebuf[0] = 32'hDEAD_BEEF;
    do_write(32'h8011_FFFC, 2'b00, wbuf, -1);
    do_read(32'h8011_FFFC, 2'b00, ebuf, 1);
    wbuf[0] = 32'h1234_5678; ebuf[0] = 32'h0;
    do_write(32'h8012_0000, 2'b00, wbuf, -1);
    do_write(32'h0000_0000, 2'b00, wbuf, -1);
    do_read(32'h8012_0000, 2'b00, ebuf, 1);
    do_read(32'h0000_0000, 2'b00, ebuf, 1);
    ebuf[0] = 32'h3C1D_8002;
    do_read(32'h8002_0000, 2'b00, ebuf, 1);

    // Enable pulsed mid-burst must be ignored
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    do_write(32'h8002_0300, 2'b01, wbuf, 2);
    ebuf[0] = 32'h3C1D_8002;
    do_read(32'h8002_0000, 2'b00, ebuf, 1);
    for (int k = 0; k < 4; k++) ebuf[k] = wbuf[k];
    do_read(32'h8002_0300, 2'b01, ebuf, 4);

    // Reset in the middle of a 16-word read
    for (int k = 0; k < 16; k++) begin wbuf[k] = 32'h100 + k; ebuf[k] = 32'h100 + k; end
    do_write(32'h8002_0400, 2'b11, wbuf, -1);
    do_read(32'h8002_0400, 2'b11, ebuf, 5);
    @(negedge clock); #2;
    reset_n = 1'b0; #1;
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_dout", data_out, 32'h0);
    @(posedge clock); #1; reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_busy", {31'b0, busy}, 32'h0);
    ebuf[0] = 32'h3C1D_8002;
    do_read(32'h8002_0000, 2'b00, ebuf, 1);
    ebuf[0] = 32'h10F;
    do_read(32'h8002_043C, 2'b00, ebuf, 1);

    repeat (3) @(posedge clock);
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
